// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: parametrised N:1 word-select mux with a registered output
// stage, valid/ready handshake on both sides, out-of-range select detection
// and a saturating error counter.
//
// Build option: define MUX_NX1_PIPE_SKID_EN to insert a 2-entry skid buffer.
// With the skid buffer, in_ready comes straight from a flop, so there is no
// combinational path from out_ready to in_ready. Without it, the block uses a
// single output register whose in_ready depends combinationally on out_ready.
module mux_nx1_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic [7:0]              err_cnt,
  input  logic                    clr_err
);

  logic [WIDTH-1:0]  words [NUM_IN];
  logic [NUM_IN-1:0] sel_hit;
  logic [WIDTH-1:0]  sel_word;
  logic              sel_err;
  logic              accept;

  logic [WIDTH-1:0]  data_reg;
  logic              err_reg;
  logic              valid_reg;
  logic [7:0]        err_cnt_reg;

  // Unpack the input bus into words and decode one hit flag per word.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_word
      assign words[gi]   = in_data[gi*WIDTH +: WIDTH];
      assign sel_hit[gi] = (in_sel == SEL_W'(gi));
    end
  endgenerate

  // Pick the addressed word; no hit means the select is out of range.
  always_comb begin
    sel_word = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_hit[k]) begin
        sel_word = words[k];
        sel_err  = 1'b0;
      end
    end
  end

`ifdef MUX_NX1_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_err_reg;
  logic             skid_valid_reg;
  logic             consume;

  // Ready is simply "skid slot empty", which is a flop output.
  assign in_ready = !skid_valid_reg;
  assign accept   = in_valid && in_ready;
  assign consume  = valid_reg && out_ready;

  // Main/skid pair: new words go to main when it frees up this cycle,
  // otherwise park in skid; skid always drains into main first (ordering).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg       <= '0;
      err_reg        <= 1'b0;
      valid_reg      <= 1'b0;
      skid_data_reg  <= '0;
      skid_err_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      if (consume) begin
        data_reg       <= skid_data_reg;
        err_reg        <= skid_err_reg;
        valid_reg      <= 1'b1;
        skid_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (!valid_reg || consume) begin
        data_reg  <= sel_word;
        err_reg   <= sel_err;
        valid_reg <= 1'b1;
      end else begin
        skid_data_reg  <= sel_word;
        skid_err_reg   <= sel_err;
        skid_valid_reg <= 1'b1;
      end
    end else if (consume) begin
      valid_reg <= 1'b0;
    end
  end
`else
  // Single stage: room whenever empty or being drained this cycle.
  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register: reload on accept (covers consume+accept without a
  // bubble), otherwise drop valid once the word is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (accept) begin
      data_reg  <= sel_word;
      err_reg   <= sel_err;
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end
`endif

  // Saturating count of accepted out-of-range selects; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (clr_err) begin
      err_cnt_reg <= 8'd0;
    end else if (accept && sel_err && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign out_valid   = valid_reg;
  assign out_data    = data_reg;
  assign out_sel_err = err_reg;
  assign err_cnt     = err_cnt_reg;

endmodule
